// File: rtl/fft_pkg.sv
// Shared constants, state type and helpers for the 32-point radix-2 SDF FFT sequencer.
package fft_pkg;

    localparam int unsigned N         = 32;
    localparam int unsigned LOG2N     = 5;
    localparam int unsigned ADV_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Stage delay table D = {16, 8, 4, 2, 1}
    function automatic int unsigned stage_delay(input int unsigned k);
        case (k)
            0:       return 16;
            1:       return 8;
            2:       return 4;
            3:       return 2;
            4:       return 1;
            default: return 0;
        endcase
    endfunction

    // Advance offset at which stage k sees sample 0 of the stream
    function automatic int unsigned stage_off(input int unsigned k, input int unsigned pipe_reg);
        int unsigned off;
        off = 0;
        for (int unsigned i = 0; i < k; i++) begin
            off = off + stage_delay(i) + pipe_reg;
        end
        return off;
    endfunction

    function automatic logic [4:0] bitrev5(input logic [4:0] x);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

endpackage

// File: rtl/fft_stage_seq.sv
// Per-stage sample counter: primes when sample 0 reaches stage K, then drives
// the butterfly select and the stage twiddle index.
module fft_stage_seq
    import fft_pkg::*;
#(
    parameter int unsigned K   = 0,
    parameter int unsigned OFF = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adv,
    input  logic                 clr,
    input  logic [ADV_CNT_W-1:0] adv_cnt,
    output logic                 bf,
    output logic [3:0]           tw
);

    // Bits of the local count below the butterfly-select bit
    localparam int unsigned TW_MASK = (1 << (LOG2N - 1 - K)) - 1;

    logic [4:0] c;
    logic       primed;

    // Local count starts on the advance that carries sample 0 into this stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c      <= '0;
            primed <= 1'b0;
        end else if (clr) begin
            c      <= '0;
            primed <= 1'b0;
        end else if (adv && (primed || (adv_cnt == ADV_CNT_W'(OFF)))) begin
            primed <= 1'b1;
            c      <= c + 5'd1;
        end
    end

    assign bf = c[LOG2N-1-K];
    assign tw = bf ? 4'd0 : 4'((c & 5'(TW_MASK)) << K);

endmodule

// File: rtl/fft_seq_ctrl.sv
// Sequencer for a 32-point radix-2 SDF FFT datapath: input handshake, flush
// padding/drain, per-stage butterfly/twiddle control and output indexing.
// Define FFT_CTRL_BITREV_EN to label outputs in natural bin order (out_idx =
// bit-reversed raw count); otherwise out_idx is the raw output count.
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned PIPE_REG = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic        adv,
    output logic        pad_zero,
    output logic [4:0]  bf_sel,
    output logic [15:0] tw_addr,
    output logic        out_valid,
    output logic [4:0]  out_idx,
    output logic        frame_done,
    output logic        busy
);

    localparam int unsigned LAT = stage_off(LOG2N - 1, PIPE_REG) + stage_delay(LOG2N - 1) + PIPE_REG;

    state_t                 state;
    logic [4:0]             in_cnt;
    logic [4:0]             r_cnt;
    logic [ADV_CNT_W-1:0]   adv_cnt;
    logic [ADV_CNT_W-1:0]   drain_cnt;
    logic                   draining;
    logic                   done;
    logic [19:0]            tw_all;
    logic [3:0]             tw_unused;

    // Handshake and status decode; adv is forced low while reset is held
    assign in_ready   = (state != ST_FLUSH);
    assign pad_zero   = (state == ST_FLUSH);
    assign busy       = (state != ST_IDLE);
    assign adv        = rst && ((state == ST_FLUSH) || in_valid);
    assign draining   = (state == ST_FLUSH) && (in_cnt == 5'd0);
    assign done       = adv && draining && (drain_cnt == ADV_CNT_W'(LAT - 1));
    assign out_valid  = adv && (adv_cnt >= ADV_CNT_W'(LAT));
    assign frame_done = out_valid && (r_cnt == 5'(N - 1));

`ifdef FFT_CTRL_BITREV_EN
    assign out_idx = bitrev5(r_cnt);
`else
    assign out_idx = r_cnt;
`endif

    // State and stream counters; end of drain returns everything to a fresh stream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            in_cnt    <= '0;
            r_cnt     <= '0;
            adv_cnt   <= '0;
            drain_cnt <= '0;
        end else if (done) begin
            state     <= ST_IDLE;
            in_cnt    <= '0;
            r_cnt     <= '0;
            adv_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) state <= ST_RUN;
                ST_RUN:  if (flush)    state <= ST_FLUSH;
                default: ;
            endcase
            if (adv) begin
                if (!draining)         in_cnt    <= in_cnt + 5'd1;
                if (draining)          drain_cnt <= drain_cnt + ADV_CNT_W'(1);
                if (adv_cnt != '1)     adv_cnt   <= adv_cnt + ADV_CNT_W'(1);
                if (out_valid)         r_cnt     <= r_cnt + 5'd1;
            end
        end
    end

    // One sequencer per stage; stage 4 has no twiddle multiplier
    for (genvar k = 0; k < LOG2N; k++) begin : g_stage
        fft_stage_seq #(
            .K   (k),
            .OFF (stage_off(k, PIPE_REG))
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .adv     (adv),
            .clr     (done),
            .adv_cnt (adv_cnt),
            .bf      (bf_sel[k]),
            .tw      (tw_all[4*k +: 4])
        );
    end

    assign tw_addr   = tw_all[15:0];
    assign tw_unused = tw_all[19:16];

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl against an advance-index reference model.
module tb_fft_seq_ctrl;

    localparam int PIPE = 1;
    localparam int NPT  = 32;

    function automatic int d_of(int k);
        case (k)
            0: return 16;
            1: return 8;
            2: return 4;
            3: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int off_of(int k);
        int o;
        o = 0;
        for (int i = 0; i < k; i++) o = o + d_of(i) + PIPE;
        return o;
    endfunction

    localparam int LAT = off_of(4) + d_of(4) + PIPE;

    function automatic logic [4:0] brev(int v);
        int o;
        o = 0;
        for (int i = 0; i < 5; i++) if (((v >> i) & 1) == 1) o = o | (1 << (4 - i));
        return 5'(o);
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        in_ready, adv, pad_zero, out_valid, frame_done, busy;
    logic [4:0]  bf_sel, out_idx;
    logic [15:0] tw_addr;

    int checks = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 run, 2 flush; m_t = advances in this stream
    int   m_phase = 0, m_t = 0, m_nin = 0, m_left = 0;
    logic cur_v, cur_f;
    logic exp_adv, exp_ready, exp_pad, exp_busy, exp_ov, exp_fd;
    logic [4:0]  exp_bf, exp_idx;
    logic [15:0] exp_tw;

    fft_seq_ctrl #(.PIPE_REG(PIPE)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .adv        (adv),
        .pad_zero   (pad_zero),
        .bf_sel     (bf_sel),
        .tw_addr    (tw_addr),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Apply inputs just after an edge and compute what the outputs must be now
    task automatic drive(input logic v, input logic f);
        int c, b, bfacc, twacc, r;
        in_valid = v;
        flush    = f;
        cur_v    = v;
        cur_f    = f;
        #2;
        exp_adv   = (m_phase == 2) ? 1'b1 : v;
        exp_ready = (m_phase != 2);
        exp_pad   = (m_phase == 2);
        exp_busy  = (m_phase != 0);
        bfacc = 0;
        twacc = 0;
        for (int k = 0; k < 5; k++) begin
            c = (m_t >= off_of(k)) ? (m_t - off_of(k)) % NPT : 0;
            b = (c >> (4 - k)) & 1;
            bfacc = bfacc | (b << k);
            if (k < 4 && b == 0) twacc = twacc | (((c % (1 << (4 - k))) << k) << (4 * k));
        end
        exp_bf = 5'(bfacc);
        exp_tw = 16'(twacc);
        r      = (m_t >= LAT) ? (m_t - LAT) % NPT : 0;
        exp_ov = exp_adv && (m_t >= LAT);
`ifdef FFT_CTRL_BITREV_EN
        exp_idx = brev(r);
`else
        exp_idx = 5'(r);
`endif
        exp_fd = exp_ov && (r == NPT - 1);
    endtask

    // Clock edge, then advance the model by the rules of the stream
    task automatic step();
        @(posedge clk);
        #1;
        case (m_phase)
            0: if (cur_v) begin m_phase = 1; m_t = 1; m_nin = 1; end
            1: begin
                if (cur_v) begin m_t++; m_nin++; end
                if (cur_f) begin
                    m_phase = 2;
                    m_left  = ((NPT - (m_nin % NPT)) % NPT) + LAT;
                end
            end
            default: begin
                m_t++;
                m_left--;
                if (m_left == 0) begin m_phase = 0; m_t = 0; m_nin = 0; end
            end
        endcase
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        rst      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        m_phase = 0; m_t = 0; m_nin = 0; m_left = 0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b1; flush = 1'b1;
        #2;
        checks++;
        if ({adv, in_ready, pad_zero, out_valid, frame_done, busy} !== 6'b010000) begin
            failures++;
            $display("FAIL reset_flags: got %b want 010000", {adv, in_ready, pad_zero, out_valid, frame_done, busy});
        end
        checks++;
        if (bf_sel !== 5'd0) begin failures++; $display("FAIL reset_bf_sel: got %0h want 0", bf_sel); end
        checks++;
        if (tw_addr !== 16'd0) begin failures++; $display("FAIL reset_tw_addr: got %0h want 0", tw_addr); end
        checks++;
        if (out_idx !== 5'd0) begin failures++; $display("FAIL reset_out_idx: got %0h want 0", out_idx); end
        do_reset();
    endtask

    task automatic test_frame();
        int first_ov, fd_at, n_ov;
        logic [4:0] seq [4];
        logic [4:0] want;
        first_ov = -1; fd_at = -1; n_ov = 0;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0);
            checks++;
            if (bf_sel[0] !== (i >= 16)) begin
                failures++; $display("FAIL frame_bf0 adv=%0d: got %b want %b", i, bf_sel[0], (i >= 16));
            end
            checks++;
            if (bf_sel !== exp_bf) begin failures++; $display("FAIL frame_bf_sel adv=%0d: got %0h want %0h", i, bf_sel, exp_bf); end
            step();
        end
        drive(1'b0, 1'b1);
        step();
        for (int n = 0; n < 200 && m_phase != 0; n++) begin
            drive(1'b0, 1'b0);
            checks++;
            if ({out_valid, frame_done, out_idx} !== {exp_ov, exp_fd, exp_idx}) begin
                failures++;
                $display("FAIL frame_out adv=%0d: got %b/%b/%0d want %b/%b/%0d", m_t, out_valid, frame_done, out_idx, exp_ov, exp_fd, exp_idx);
            end
            if (out_valid === 1'b1) begin
                if (first_ov < 0) first_ov = m_t;
                if (n_ov < 4) seq[n_ov] = out_idx;
                n_ov++;
            end
            if (frame_done === 1'b1) fd_at = m_t;
            step();
        end
        checks++;
        if (first_ov != 36) begin failures++; $display("FAIL frame_first_ov: got %0d want 36", first_ov); end
        checks++;
        if (fd_at != 67) begin failures++; $display("FAIL frame_done_adv: got %0d want 67", fd_at); end
        checks++;
        if (n_ov != 32) begin failures++; $display("FAIL frame_ov_count: got %0d want 32", n_ov); end
        for (int i = 0; i < 4 && i < n_ov; i++) begin
`ifdef FFT_CTRL_BITREV_EN
            want = brev(i);
`else
            want = 5'(i);
`endif
            checks++;
            if (seq[i] !== want) begin failures++; $display("FAIL frame_idx_seq[%0d]: got %0d want %0d", i, seq[i], want); end
        end
        drive(1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL frame_busy_after: got %b want 0", busy); end
        step();
    endtask

    task automatic test_gap();
        int cyc, first;
        cyc = 0; first = -1;
        do_reset();
        for (int i = 0; i < 11; i++) begin drive(1'b1, 1'b0); step(); cyc++; end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0);
            checks++;
            if ({adv, out_valid} !== 2'b00) begin failures++; $display("FAIL gap_adv: got %b%b want 00", adv, out_valid); end
            checks++;
            if ({bf_sel, tw_addr, out_idx} !== {exp_bf, exp_tw, exp_idx}) begin
                failures++;
                $display("FAIL gap_frozen: got %0h/%0h/%0h want %0h/%0h/%0h", bf_sel, tw_addr, out_idx, exp_bf, exp_tw, exp_idx);
            end
            step(); cyc++;
        end
        for (int n = 0; n < 100 && first < 0; n++) begin
            drive(1'b1, 1'b0);
            checks++;
            if (out_valid !== exp_ov) begin failures++; $display("FAIL gap_ov cyc=%0d: got %b want %b", cyc, out_valid, exp_ov); end
            if (out_valid === 1'b1) first = cyc;
            step(); cyc++;
        end
        checks++;
        if (first != 41) begin failures++; $display("FAIL gap_first_ov_cycle: got %0d want 41", first); end
    endtask

    task automatic test_flush_mid();
        int n_fl, n_ov;
        n_fl = 0; n_ov = 0;
        do_reset();
        for (int i = 0; i < 21; i++) begin drive(1'b1, 1'b0); step(); end
        drive(1'b0, 1'b1);
        step();
        for (int n = 0; n < 200 && m_phase != 0; n++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if ({in_ready, adv, pad_zero, out_valid} !== {exp_ready, exp_adv, exp_pad, exp_ov}) begin
                failures++;
                $display("FAIL flush_ctl adv=%0d: got %b want %b", m_t, {in_ready, adv, pad_zero, out_valid}, {exp_ready, exp_adv, exp_pad, exp_ov});
            end
            if (in_ready === 1'b0) n_fl++;
            if (out_valid === 1'b1) n_ov++;
            step();
        end
        checks++;
        if (n_fl != 11 + 36) begin failures++; $display("FAIL flush_cycles: got %0d want 47", n_fl); end
        checks++;
        if (n_ov != 32) begin failures++; $display("FAIL flush_ov_count: got %0d want 32", n_ov); end
        drive(1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy_after: got %b want 0", busy); end
        step();
    endtask

    task automatic test_tw();
        do_reset();
        for (int n = 0; n < 30; n++) begin
            drive(1'b1, 1'b0);
            checks++;
            if (tw_addr !== exp_tw) begin failures++; $display("FAIL tw_addr adv=%0d: got %0h want %0h", m_t, tw_addr, exp_tw); end
            if (m_t == 22) begin
                checks++;
                if ({bf_sel[1], tw_addr[7:4]} !== {1'b0, 4'd10}) begin
                    failures++; $display("FAIL tw_stage1_c5: got bf=%b tw=%0d want bf=0 tw=10", bf_sel[1], tw_addr[7:4]);
                end
            end
            if (m_t == 25) begin
                checks++;
                if ({bf_sel[1], tw_addr[7:4]} !== {1'b1, 4'd0}) begin
                    failures++; $display("FAIL tw_stage1_bf: got bf=%b tw=%0d want bf=1 tw=0", bf_sel[1], tw_addr[7:4]);
                end
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        int first;
        first = -1;
        do_reset();
        for (int i = 0; i < 14; i++) begin drive(1'b1, 1'b0); step(); end
        drive(1'b1, 1'b0);
        rst = 1'b0;
        #1;
        checks++;
        if ({adv, in_ready, pad_zero, out_valid, frame_done, busy} !== 6'b010000) begin
            failures++;
            $display("FAIL async_flags: got %b want 010000", {adv, in_ready, pad_zero, out_valid, frame_done, busy});
        end
        checks++;
        if ({bf_sel, tw_addr, out_idx} !== 26'd0) begin
            failures++; $display("FAIL async_ctl: got %0h/%0h/%0h want 0", bf_sel, tw_addr, out_idx);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        m_phase = 0; m_t = 0; m_nin = 0; m_left = 0;
        for (int n = 0; n < 40; n++) begin
            drive(1'b1, 1'b0);
            if (n == 0) begin
                checks++;
                if (bf_sel[0] !== 1'b0) begin failures++; $display("FAIL async_restart_bf0: got %b want 0", bf_sel[0]); end
            end
            checks++;
            if (out_valid !== exp_ov) begin failures++; $display("FAIL async_ov adv=%0d: got %b want %b", n, out_valid, exp_ov); end
            if (out_valid === 1'b1 && first < 0) first = n;
            step();
        end
        checks++;
        if (first != 36) begin failures++; $display("FAIL async_first_ov: got %0d want 36", first); end
    endtask

    task automatic test_back_to_back();
        int n_fd;
        n_fd = 0;
        do_reset();
        for (int n = 0; n < 100; n++) begin
            drive(1'b1, 1'b0);
            checks++;
            if ({in_ready, busy, out_valid, out_idx} !== {exp_ready, exp_busy, exp_ov, exp_idx}) begin
                failures++;
                $display("FAIL b2b adv=%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", n, in_ready, busy, out_valid, out_idx, exp_ready, exp_busy, exp_ov, exp_idx);
            end
            if (frame_done === 1'b1) n_fd++;
            step();
        end
        checks++;
        if (n_fd != 2) begin failures++; $display("FAIL b2b_frame_done_count: got %0d want 2", n_fd); end
    endtask

    task automatic test_random();
        logic v, f;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            v = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 59) == 0);
            drive(v, f);
            checks++;
            if ({adv, in_ready, pad_zero, busy, out_valid, frame_done} !== {exp_adv, exp_ready, exp_pad, exp_busy, exp_ov, exp_fd}) begin
                failures++;
                $display("FAIL rand_flags n=%0d: got %b want %b", n, {adv, in_ready, pad_zero, busy, out_valid, frame_done}, {exp_adv, exp_ready, exp_pad, exp_busy, exp_ov, exp_fd});
            end
            checks++;
            if ({bf_sel, tw_addr, out_idx} !== {exp_bf, exp_tw, exp_idx}) begin
                failures++;
                $display("FAIL rand_ctl n=%0d: got %0h/%0h/%0h want %0h/%0h/%0h", n, bf_sel, tw_addr, out_idx, exp_bf, exp_tw, exp_idx);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_gap();
        test_flush_mid();
        test_tw();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
